matrix_loader: RTL and testbench

Byte-serial writer that assembles a square matrix of signed 8-bit elements into the 200-bit row-major flat bus used by the matrix arithmetic units (determinant, etc.). It accepts one element per valid/ready handshake from the host/bus side and places it at its position in a 5x5 grid. It zero-fills all unused slots and presents the finished matrix with a valid/ack handshake toward the arithmetic unit.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_index_counter.sv | 39 +++
 rtl/matrix_loader.sv | 98 +++++++++
 tb/tb_matrix_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix arithmetic slice: element/grid geometry,
// the loader state encoding and the flat-bus slot addressing helper.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int MAX_N  = 5;
  localparam int FLAT_W = MAX_N * MAX_N * ELEM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } loader_state_t;

  // LSB of element (row,col) on the row-major flat bus; the stride is always
  // MAX_N so consumers can decode any order with the same formula.
  function automatic int slot_lsb(input int row, input int col);
    return ELEM_W * (MAX_N * row + col);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column position counter for the matrix loader. The column wraps at the
// configured order and carries into the row; 'last' flags the final slot.
module matrix_index_counter
  import matrix_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       step,
  input  logic [2:0] order,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] top_index;

  assign top_index = order - 3'd1;
  assign last      = (row == top_index) && (col == top_index);

  // Advance one slot per accepted element; clear restarts at (0,0).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (clear) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (step) begin
      if (col == top_index) begin
        col <= 3'd0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Byte-serial matrix loader: accepts one signed element per valid/ready
// handshake, places it in a zero-padded 5x5 row-major flat bus and presents
// the finished matrix with a valid/ack handshake.
module matrix_loader
  import matrix_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        cfg_n,
  input  logic              load_start,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLAT_W-1:0] A_flat,
  output logic              matrix_valid,
  input  logic              matrix_ack,
  output logic              busy,
  output logic              cfg_error
);

  loader_state_t state;
  logic [2:0]    order;
  logic [2:0]    row;
  logic [2:0]    col;
  logic          last;
  logic          cfg_legal;
  logic          start_ok;
  logic          start_bad;
  logic          accept;

  assign cfg_legal = (cfg_n != 3'd0) && (cfg_n <= 3'(MAX_N));
  assign start_ok  = (state == IDLE) && load_start && cfg_legal;
  assign start_bad = (state == IDLE) && load_start && !cfg_legal;
  assign accept    = (state == LOAD) && in_valid;

  // Handshake outputs come straight from the registered state.
  assign in_ready     = (state == LOAD);
  assign matrix_valid = (state == HOLD);
  assign busy         = (state != IDLE);

  matrix_index_counter u_index (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start_ok),
    .step    (accept),
    .order   (order),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Loader FSM: IDLE -> LOAD on a legal start, LOAD -> HOLD on the final
  // element, HOLD -> IDLE when the consumer acknowledges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok)        state <= LOAD;
        LOAD:    if (accept && last)  state <= HOLD;
        HOLD:    if (matrix_ack)      state <= IDLE;
        default:                      state <= IDLE;
      endcase
    end
  end

  // Latch the matrix order and track the sticky configuration error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      order     <= 3'd1;
      cfg_error <= 1'b0;
    end else if (start_ok) begin
      order     <= cfg_n;
      cfg_error <= 1'b0;
    end else if (start_bad) begin
      cfg_error <= 1'b1;
    end
  end

  // Flat matrix register: cleared on a legal start so unused slots read zero,
  // then written one slot per accepted element; held otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      A_flat <= '0;
    end else if (start_ok) begin
      A_flat <= '0;
    end else if (accept) begin
      for (int r = 0; r < MAX_N; r++) begin
        for (int c = 0; c < MAX_N; c++) begin
          if ((row == 3'(r)) && (col == 3'(c))) begin
            A_flat[slot_lsb(r, c) +: ELEM_W] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: directed and randomized loads checked
// against a queue-based reference of the expected row-major matrix.
module tb_matrix_loader;

  logic         clock;
  logic         reset_n;
  logic [2:0]   cfg_n;
  logic         load_start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] A_flat;
  logic         matrix_valid;
  logic         matrix_ack;
  logic         busy;
  logic         cfg_error;

  int checks;
  int passes;
  int fails;

  logic [199:0] exp_flat;
  logic [7:0]   el[$];

  matrix_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_n        (cfg_n),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A_flat       (A_flat),
    .matrix_valid (matrix_valid),
    .matrix_ack   (matrix_ack),
    .busy         (busy),
    .cfg_error    (cfg_error)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: element i of an order-n load lands at row i/n, column i%n
  function automatic logic [199:0] build_flat(input int n, input logic [7:0] q[$], input int cnt);
    logic [199:0] f;
    f = '0;
    for (int i = 0; i < cnt; i++) f[8 * (5 * (i / n) + (i % n)) +: 8] = q[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one load_start in IDLE and check the outcome
  task automatic start_load(input logic [2:0] n, input logic [199:0] prev);
    bit legal;
    legal = (n >= 3'd1) && (n <= 3'd5);
    cfg_n = n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_bit("busy after start", busy, legal);
    check_bit("in_ready after start", in_ready, legal);
    check_bit("cfg_error after start", cfg_error, !legal);
    check_bit("matrix_valid after start", matrix_valid, 1'b0);
    check_output("A_flat after start", A_flat, legal ? 200'd0 : prev);
  endtask

  // Feed n*n elements with random gaps; optionally poke ignored inputs
  task automatic feed(input int n, input logic [7:0] q[$], input int gap_pct, input bit poke, output int cyc);
    int idx;
    idx = 0;
    cyc = 0;
    while (idx < n * n && cyc < 1000) begin
      check_bit("in_ready in load", in_ready, 1'b1);
      in_valid   = ($urandom_range(0, 99) >= gap_pct);
      in_data    = q[idx];
      load_start = poke && ($urandom_range(0, 3) == 0);
      matrix_ack = poke && ($urandom_range(0, 3) == 0);
      cfg_n      = 3'd1;
      tick();
      cyc++;
      if (in_valid) idx++;
      in_valid   = 1'b0;
      load_start = 1'b0;
      matrix_ack = 1'b0;
      check_output("partial matrix", A_flat, build_flat(n, q, idx));
      if (poke) check_bit("cfg_error untouched in load", cfg_error, 1'b0);
    end
    if (idx < n * n) begin
      checks++;
      fails++;
      $error("[TB] FAIL feed timeout: observed %0d elements expected %0d", idx, n * n);
    end
    check_bit("matrix_valid after last", matrix_valid, 1'b1);
    check_bit("in_ready after last", in_ready, 1'b0);
  endtask

  // Sit in HOLD with in_valid asserted; nothing may change
  task automatic hold_cycles(input int k, input logic [199:0] expv);
    for (int i = 0; i < k; i++) begin
      in_valid   = 1'b1;
      in_data    = 8'($urandom);
      load_start = ($urandom_range(0, 1) == 1);
      cfg_n      = 3'd2;
      tick();
      in_valid   = 1'b0;
      load_start = 1'b0;
      check_bit("in_ready in hold", in_ready, 1'b0);
      check_bit("matrix_valid in hold", matrix_valid, 1'b1);
      check_output("A_flat frozen in hold", A_flat, expv);
    end
  endtask

  task automatic ack_matrix(input logic [199:0] expv);
    matrix_ack = 1'b1;
    tick();
    matrix_ack = 1'b0;
    check_bit("matrix_valid after ack", matrix_valid, 1'b0);
    check_bit("busy after ack", busy, 1'b0);
    check_output("A_flat kept after ack", A_flat, expv);
  endtask

  task automatic random_elems(input int n);
    el = {};
    for (int i = 0; i < n * n; i++) el.push_back(8'($urandom));
  endtask

  initial begin
    int cyc;
    int det;
    checks = 0;
    passes = 0;
    fails = 0;
    reset_n = 1'b0;
    cfg_n = 3'd0;
    load_start = 1'b0;
    in_data = 8'd0;
    in_valid = 1'b0;
    matrix_ack = 1'b0;
    #3;
    check_bit("reset in_ready", in_ready, 1'b0);
    check_bit("reset matrix_valid", matrix_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset cfg_error", cfg_error, 1'b0);
    check_output("reset A_flat", A_flat, 200'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // N=2, elements 3,-2,5,4, continuous
    $display("[TB] N=2 continuous load");
    el = {8'd3, 8'hFE, 8'd5, 8'd4};
    exp_flat = build_flat(2, el, 4);
    start_load(3'd2, 200'd0);
    feed(2, el, 0, 1'b0, cyc);
    check_int("cycles to matrix_valid N=2", cyc + 1, 5);
    check_output("N=2 matrix", A_flat, exp_flat);
    check_output("N=2 explicit layout", A_flat,
                 {144'd0, 8'h04, 8'h05, 24'd0, 8'hFE, 8'h03});
    det = int'($signed(A_flat[7:0])) * int'($signed(A_flat[55:48]))
        - int'($signed(A_flat[15:8])) * int'($signed(A_flat[47:40]));
    check_int("N=2 determinant", det, 22);
    hold_cycles(3, exp_flat);
    ack_matrix(exp_flat);

    // ack outside HOLD is ignored
    matrix_ack = 1'b1;
    tick();
    matrix_ack = 1'b0;
    check_bit("ack in idle busy", busy, 1'b0);
    check_output("ack in idle A_flat", A_flat, exp_flat);

    // N=5, element k = k, random gaps
    $display("[TB] N=5 ramp with gaps");
    el = {};
    for (int k = 0; k < 25; k++) el.push_back(8'(k));
    exp_flat = build_flat(5, el, 25);
    start_load(3'd5, exp_flat);
    feed(5, el, 40, 1'b0, cyc);
    for (int k = 0; k < 25; k++) check_int("N=5 slot", int'(A_flat[8 * k +: 8]), k);
    hold_cycles(4, exp_flat);
    ack_matrix(exp_flat);

    // N=3 of 0x7F, then N=2 of ones: zero padding on reload
    $display("[TB] reload zero padding");
    el = {};
    for (int k = 0; k < 9; k++) el.push_back(8'h7F);
    exp_flat = build_flat(3, el, 9);
    start_load(3'd3, exp_flat);
    feed(3, el, 0, 1'b0, cyc);
    check_output("N=3 matrix", A_flat, exp_flat);
    ack_matrix(exp_flat);
    el = {8'd1, 8'd1, 8'd1, 8'd1};
    start_load(3'd2, exp_flat);
    feed(2, el, 20, 1'b0, cyc);
    exp_flat = build_flat(2, el, 4);
    check_output("reload bits 23:16", {192'd0, A_flat[23:16]}, 200'd0);
    check_output("reload bits 71:64", {192'd0, A_flat[71:64]}, 200'd0);
    check_output("reload matrix", A_flat, exp_flat);
    ack_matrix(exp_flat);

    // Illegal orders
    $display("[TB] illegal orders");
    start_load(3'd0, exp_flat);
    start_load(3'd6, exp_flat);
    start_load(3'd7, exp_flat);
    random_elems(2);
    start_load(3'd2, exp_flat);
    feed(2, el, 30, 1'b1, cyc);
    exp_flat = build_flat(2, el, 4);
    check_output("after error recovery", A_flat, exp_flat);
    ack_matrix(exp_flat);

    // Reset after 3 of 4 elements
    $display("[TB] reset mid-load");
    random_elems(2);
    start_load(3'd2, exp_flat);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = el[i];
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_bit("mid-load reset in_ready", in_ready, 1'b0);
    check_bit("mid-load reset busy", busy, 1'b0);
    check_bit("mid-load reset matrix_valid", matrix_valid, 1'b0);
    check_bit("mid-load reset cfg_error", cfg_error, 1'b0);
    check_output("mid-load reset A_flat", A_flat, 200'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    random_elems(4);
    start_load(3'd4, 200'd0);
    feed(4, el, 30, 1'b0, cyc);
    exp_flat = build_flat(4, el, 16);
    check_output("post-reset matrix", A_flat, exp_flat);
    ack_matrix(exp_flat);

    // Ack in the first HOLD cycle
    $display("[TB] first-cycle ack");
    random_elems(3);
    start_load(3'd3, exp_flat);
    feed(3, el, 0, 1'b1, cyc);
    exp_flat = build_flat(3, el, 9);
    ack_matrix(exp_flat);

    // load_start in HOLD is ignored
    $display("[TB] start during hold");
    random_elems(3);
    start_load(3'd3, exp_flat);
    feed(3, el, 10, 1'b0, cyc);
    exp_flat = build_flat(3, el, 9);
    cfg_n = 3'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_bit("start in hold valid", matrix_valid, 1'b1);
    check_bit("start in hold cfg_error", cfg_error, 1'b0);
    check_output("start in hold A_flat", A_flat, exp_flat);
    ack_matrix(exp_flat);

    // N=1 with a negative element
    $display("[TB] N=1");
    el = {8'h80};
    start_load(3'd1, exp_flat);
    feed(1, el, 0, 1'b0, cyc);
    check_int("cycles to matrix_valid N=1", cyc + 1, 2);
    exp_flat = build_flat(1, el, 1);
    check_output("N=1 matrix", A_flat, {192'd0, 8'h80});
    ack_matrix(exp_flat);

    // Random orders and contents
    $display("[TB] random loads");
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 5);
      random_elems(n);
      start_load(3'(n), exp_flat);
      feed(n, el, $urandom_range(0, 60), 1'($urandom_range(0, 1)), cyc);
      exp_flat = build_flat(n, el, n * n);
      hold_cycles($urandom_range(0, 3), exp_flat);
      ack_matrix(exp_flat);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
